// File: rtl/mul_arb.sv
// Round-robin controller sharing one 8x8 cs/rdy multiplier among NREQ requesters.
// Optional build macro MUL_ARB_TIMEOUT_EN adds a TIMEOUT-cycle abort on a stuck multiplier.
module mul_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] opa,
    input  logic [NREQ*8-1:0] opb,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [15:0]       result,
    output logic              busy,
    output logic              err,
    output logic              mul_cs,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    input  logic [15:0]       mul_result,
    input  logic              mul_rdy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mul_arb: NREQ must be 2..8 and TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {ARB, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] sel;
    logic          expired;

    // First pending requester at or after p, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb sel = rr_pick(req, ptr);

    assign busy = (state != ARB);

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;

    assign expired = (tcnt == TW'(TIMEOUT - 1));
    assign err     = err_q;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB;
            ptr    <= '0;
            owner  <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            mul_cs <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            mul_cs <= 1'b0;
            done   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
            if (state == ISSUE)
                tcnt <= '0;
            else if (state == WAIT_LO || state == WAIT_HI)
                tcnt <= tcnt + 1'b1;
`endif
            case (state)
                ARB: begin
                    if (|req) begin
                        owner  <= sel;
                        gnt    <= NREQ'(1) << sel;
                        mul_a  <= {8'h00, opa[int'(sel)*8 +: 8]};
                        mul_b  <= {8'h00, opb[int'(sel)*8 +: 8]};
                        mul_cs <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_LO;
                WAIT_LO, WAIT_HI: begin
                    if (expired) begin
                        result <= 16'hFFFF;
                        done   <= gnt;
                        state  <= DONE;
`ifdef MUL_ARB_TIMEOUT_EN
                        err_q  <= 1'b1;
`endif
                    end else if (state == WAIT_LO && !mul_rdy) begin
                        // rdy idles high; the low phase proves the multiplier took our cs.
                        state <= WAIT_HI;
                    end else if (state == WAIT_HI && mul_rdy) begin
                        result <= mul_result;
                        done   <= gnt;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    gnt   <= '0;
                    state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: directed vector table, multi-cycle corner sequences,
// and a randomized run checked against a request-queue reference model.
module tb_mul_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 3;   // grant edge -> done: ISSUE, WAIT_LO, WAIT_HI, then DONE

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*8-1:0] opa = '0;
    logic [NREQ*8-1:0] opb = '0;
    logic [NREQ-1:0]   gnt, done;
    logic [15:0]       result, mul_a, mul_b;
    logic              busy, err, mul_cs;
    logic [15:0]       mul_result = 16'h0000;
    logic              mul_rdy    = 1'b1;
    logic              mul_pend   = 1'b0;
    logic [15:0]       mul_prod   = 16'h0000;
    logic              stuck      = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .done(done), .result(result), .busy(busy), .err(err),
        .mul_cs(mul_cs), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_rdy(mul_rdy)
    );

    // Nominal multiplier: rdy drops the cycle after cs, rises with the product the next.
    always @(posedge clk) begin
        if (mul_cs && !stuck) begin
            mul_rdy    <= 1'b0;
            mul_pend   <= 1'b1;
            mul_prod   <= 16'(mul_a[7:0]) * 16'(mul_b[7:0]);
            mul_result <= 16'hDEAD;
        end else if (mul_pend) begin
            mul_rdy    <= 1'b1;
            mul_result <= mul_prod;
            mul_pend   <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        opa[8*i +: 8] = a;
        opb[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one operation for requester own (req already set by the caller).
    // drop_cyc / chg_cyc: cycle after grant (1=WAIT_LO, 2=WAIT_HI) to drop req / rewrite opa.
    task automatic do_op(input string name, input int own, input logic [15:0] exp_res,
                         input logic exp_err, input int exp_lat, input int drop_cyc,
                         input int chg_cyc, input logic [7:0] chg_a);
        int w, lat, ncs;
        logic [7:0] a0, b0;
        a0 = opa[8*own +: 8];
        b0 = opb[8*own +: 8];
        w  = 0;
        do begin
            @(negedge clk);
            w++;
        end while (gnt == '0 && w < 20);
        if (gnt == '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s grant: no grant within 20 cycles, expected gnt=%0h", name, 1 << own);
            return;
        end
        check({name, " gnt"}, gnt, 1 << own);
        check({name, " mul_a"}, mul_a, {8'h00, a0});
        check({name, " mul_b"}, mul_b, {8'h00, b0});
        ncs = int'(mul_cs);
        lat = 0;
        while (done == '0 && lat < 60) begin
            if (lat == chg_cyc) opa[8*own +: 8] = chg_a;
            if (lat == drop_cyc) req[own] = 1'b0;
            @(negedge clk);
            lat++;
            ncs += int'(mul_cs);
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " done"}, done, 1 << own);
        check({name, " gnt@done"}, gnt, 1 << own);
        check({name, " result"}, result, exp_res);
        check({name, " err"}, err, exp_err);
        check({name, " busy@done"}, busy, 1);
        req[own] = 1'b0;
        @(negedge clk);
        ncs += int'(mul_cs);
        check({name, " busy after"}, busy, 0);
        check({name, " gnt after"}, {done, gnt}, 0);
        check({name, " cs pulses"}, ncs, 1);
    endtask

    typedef struct {
        logic [NREQ-1:0] mask;
        int              own;
        logic [7:0]      a;
        logic [7:0]      b;
        logic [15:0]     res;
    } vec_t;

    vec_t tbl[5];

    // Reference-model state for the randomized run.
    logic [7:0]  ra[NREQ];
    logic [7:0]  rb[NREQ];
    int          waited[NREQ];
    int          ptr_m, cur, gcyc, ops, cyc, exp_own;
    logic [NREQ-1:0] prev_gnt;
    logic [15:0] exp_p;
    logic        saw_done;

    initial begin
        tbl[0] = '{4'b0010, 1, 8'd12,  8'd13,  16'd156};
        tbl[1] = '{4'b0100, 2, 8'd255, 8'd255, 16'hFE01};
        tbl[2] = '{4'b0001, 0, 8'd0,   8'd200, 16'd0};
        tbl[3] = '{4'b1000, 3, 8'd1,   8'd1,   16'd1};
        tbl[4] = '{4'b1000, 3, 8'd17,  8'd15,  16'd255};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset gnt/done", {gnt, done}, 0);
        check("reset result", result, 0);
        check("reset flags", {busy, err, mul_cs}, 0);
        check("reset mul_a/b", {mul_a, mul_b}, 0);
        rst = 1'b0;

        // Single-request vectors
        for (int i = 0; i < 5; i++) begin
            set_ops(tbl[i].own, tbl[i].a, tbl[i].b);
            req = tbl[i].mask;
            do_op($sformatf("vec%0d", i), tbl[i].own, tbl[i].res, 1'b0, LAT, -1, -1, 8'h00);
        end

        // Request withdrawn in WAIT_HI still completes
        set_ops(2, 8'd20, 8'd30);
        req = 4'b0100;
        do_op("withdrawn", 2, 16'd600, 1'b0, LAT, 2, -1, 8'h00);

        // Operand change after grant is ignored
        set_ops(0, 8'd4, 8'd10);
        req = 4'b0001;
        do_op("opchange", 0, 16'd40, 1'b0, LAT, -1, 1, 8'd9);

`ifdef MUL_ARB_TIMEOUT_EN
        // Multiplier never drops rdy: abort after TIMEOUT wait cycles
        stuck = 1'b1;
        set_ops(1, 8'd5, 8'd5);
        req = 4'b0010;
        do_op("timeout", 1, 16'hFFFF, 1'b1, 1 + TIMEOUT, -1, -1, 8'h00);
        stuck = 1'b0;
        set_ops(2, 8'd2, 8'd3);
        req = 4'b0100;
        do_op("after timeout", 2, 16'd6, 1'b0, LAT, -1, -1, 8'h00);
`endif

        // Round-robin with all four requesting
        do_reset();
        set_ops(0, 8'd3, 8'd5);
        set_ops(1, 8'd7, 8'd9);
        set_ops(2, 8'd255, 8'd255);
        set_ops(3, 8'd0, 8'd200);
        req = 4'b1111;
        do_op("rr0", 0, 16'd15, 1'b0, LAT, -1, -1, 8'h00);
        req[0] = 1'b1;
        do_op("rr1", 1, 16'd63, 1'b0, LAT, -1, -1, 8'h00);
        req[1] = 1'b1;
        do_op("rr2", 2, 16'hFE01, 1'b0, LAT, -1, -1, 8'h00);
        req[2] = 1'b1;
        do_op("rr3", 3, 16'd0, 1'b0, LAT, -1, -1, 8'h00);
        req[3] = 1'b1;
        do_op("rr4", 0, 16'd15, 1'b0, LAT, -1, -1, 8'h00);

        // Reset in WAIT_LO abandons the operation (pointer is 1 going in)
        req = 4'b0100;
        do @(negedge clk); while (gnt == '0 && busy == 1'b0 && result == 16'd15);
        check("rstmid gnt", gnt, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rstmid gnt/done", {gnt, done}, 0);
        check("rstmid result", result, 0);
        check("rstmid flags", {busy, err, mul_cs}, 0);
        check("rstmid mul_a/b", {mul_a, mul_b}, 0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_done |= |done;
        end
        check("rstmid no done", saw_done, 0);
        // Pointer back at 0: requester 0 wins over 3
        set_ops(0, 8'd6, 8'd7);
        set_ops(3, 8'd11, 8'd11);
        req = 4'b1001;
        do_op("rstmid ptr0", 0, 16'd42, 1'b0, LAT, -1, -1, 8'h00);
        do_op("rstmid req3", 3, 16'd121, 1'b0, LAT, -1, -1, 8'h00);

        // Randomized traffic against a request-set reference model
        do_reset();
        ptr_m = 0;
        cur = 0;
        gcyc = 0;
        ops = 0;
        cyc = 0;
        prev_gnt = '0;
        for (int j = 0; j < NREQ; j++) waited[j] = 0;
        while (ops < 40 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0 && prev_gnt == '0) begin
                exp_own = -1;
                for (int k = 0; k < NREQ; k++)
                    if (exp_own < 0 && req[(ptr_m + k) % NREQ]) exp_own = (ptr_m + k) % NREQ;
                check("rand grant", gnt, 1 << exp_own);
                check("rand fairness", waited[exp_own] <= NREQ - 1, 1);
                for (int j = 0; j < NREQ; j++) if (j != exp_own && req[j]) waited[j]++;
                waited[exp_own] = 0;
                cur = exp_own;
                gcyc = cyc;
            end
            if (done != '0) begin
                exp_p = 16'(ra[cur]) * 16'(rb[cur]);
                check("rand done", done, 1 << cur);
                check("rand result", result, exp_p);
                check("rand latency", cyc - gcyc, LAT);
                check("rand err", err, 0);
                ptr_m = (cur + 1) % NREQ;
                req[cur] = 1'b0;
                ops++;
            end
            prev_gnt = gnt;
            for (int j = 0; j < NREQ; j++) begin
                if (!req[j] && !done[j] && $urandom_range(2) == 0) begin
                    ra[j] = 8'($urandom);
                    rb[j] = 8'($urandom);
                    set_ops(j, ra[j], rb[j]);
                    req[j] = 1'b1;
                end
            end
        end
        if (ops < 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand progress: %0d operations completed, expected 40", ops);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
